mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
- Multi-cycle control FSM that sequences the single-ported MIPS datapath through five phases: FETCH, DECODE, EXEC, MEM and WB.
- The datapath around it is the instruction decoder, register file, ALU, PC register, and instruction and data memories.
- Inputs are the decoder's control fields plus ready/flag inputs from memory and the ALU.
- It drives the per-cycle enables and selects, handles variable-latency memory handshakes with a timeout, and counts retired instructions.

Parameters:
- DWIDTH, 32, width of the retired-instruction counter.
- TMO_W, 4, width of the memory-wait timeout counter.
- TMO_MAX, 15, maximum cycles to wait on a ready input; must be at most 2^TMO_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  level; leave IDLE and begin fetching.
- halt  in  1  level; sampled only at a retire boundary.
- imem_ready  in  1  instruction word valid this cycle.
- dmem_ready  in  1  data access complete this cycle.
- jump_type  in  3  decoder: 000 nop, 001 beq, 010 jal, 011 jr, 100 j, 101 bodd.
- we_dmem  in  1  decoder: store.
- we_regfile  in  1  decoder: register writeback requested.
- en_rdata  in  1  decoder: load.
- alu_zero  in  1  rs1 == rs2, valid in EXEC.
- rs1_odd  in  1  bit 0 of rs1 value, valid in EXEC.
- imem_req  out  1  instruction fetch request.
- ir_we  out  1  latch the instruction register.
- pc_we  out  1  PC write enable.
- pc_sel  out  2  00 PC+4, 01 PC+4+(imm<<2), 10 jump_addr<<2, 11 rs1 value.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (valid with dmem_req).
- rf_we  out  1  register file write.
- rf_wsel  out  2  write data source: 00 ALU, 01 dmem rdata, 10 link (PC).
- busy  out  1  state is not IDLE and not ERR.
- err  out  1  sticky timeout flag.
- retired  out  DWIDTH  count of retired instructions.
- state  out  3  IDLE 000, FETCH 001, DECODE 010, EXEC 011, MEM 100, WB 101, ERR 111.

Behaviour:
- Reset (asynchronous): state=IDLE, retired=0, err=0, timeout counter=0.
  - While in reset, every other output is 0.
- Outputs are decoded combinationally from the state; ir_we, pc_we and dmem completion also depend on the ready inputs as stated below.
- Default output value is 0 for every output not asserted by the current state.
- IDLE: go to FETCH when run=1, otherwise stay.
- FETCH:
  - imem_req=1.
  - On imem_ready=1: ir_we=1, pc_we=1, pc_sel=00, next state DECODE.
  - Otherwise increment the timeout counter.
- DECODE: one cycle, no outputs asserted; next state EXEC.
- EXEC: one cycle; exit depends on jump_type:
  - beq: if alu_zero, pc_we=1 and pc_sel=01; retire.
  - bodd: if rs1_odd, pc_we=1 and pc_sel=01; retire.
  - j: pc_we=1, pc_sel=10; retire.
  - jr: pc_we=1, pc_sel=11; retire.
  - jal: pc_we=1, pc_sel=10; next state WB with the link write.
  - nop type with we_dmem or en_rdata set: next state MEM.
  - nop type with we_regfile set: next state WB.
  - Anything else, including undefined opcodes (all decoder flags 0): retire as a no-op.
- Branch and jump types never write the register file, even when we_regfile=1.
- MEM:
  - dmem_req=1, dmem_we=we_dmem.
  - On dmem_ready=1: a store retires; a load goes to WB.
  - Otherwise increment the timeout counter.
- WB: one cycle, rf_we=1.
  - rf_wsel=10 for jal, 01 for a load, 00 otherwise.
  - Then retire.
- Retire:
  - retired increments by 1 and wraps modulo 2^DWIDTH.
  - Next state is IDLE if halt=1, else FETCH.
  - A halt asserted mid-instruction has no effect until the retire cycle.
- Timeout counter:
  - Cleared on every state change.
  - Reaching TMO_MAX in FETCH or MEM moves to ERR and sets err=1.
- ERR: all enables 0; exit only by reset.
- Ready arriving on the same cycle the count hits TMO_MAX: ready wins and the access completes normally.
- Decoder inputs are sampled while in EXEC, MEM and WB; the IR is held stable, so they are constant across those states.
- rst asserted mid-access drops every request in the same cycle and returns to IDLE.
- Latency with zero-wait memory:
  - ALU op: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - Branch or jump: 3 cycles.
  - jal: 4 cycles.

Test Plan:
- Reset, run=1, add instruction, imem_ready tied 1 → states 001,010,011,101,001; rf_we=1 and rf_wsel=00 in WB; retired=1 after 4 cycles.
- lw with dmem_ready arriving 2 cycles late → dmem_req high 3 cycles, dmem_we=0, then WB with rf_wsel=01; total 7 cycles; retired+1.
- beq with alu_zero=1 vs alu_zero=0 → pc_we=1 and pc_sel=01 in EXEC vs pc_we=0 in EXEC; rf_we never 1 in either case; both retire in 3 cycles.
- jal → EXEC pc_we=1 and pc_sel=10, then WB rf_we=1 and rf_wsel=10.
- jr (we_regfile=1) → EXEC pc_sel=11 with no WB.
- imem_ready held 0 → ERR entered with err=1; ready asserted afterwards is ignored until rst; rst clears err and retired and returns to state=000.
- retired preset near wrap via 2^DWIDTH-1 retires (use DWIDTH=4 build: 15 retires) → the next retire gives retired=0.
- halt=1 raised during MEM of a sw → sw completes, retires, then IDLE.

Source files
------------

// File: rtl/mc_ctrl.sv
// ---------------------------------------------------------------------------
// mc_ctrl
//
// Control FSM for the multi-cycle, single-ported MIPS datapath. Each
// instruction is walked through FETCH, DECODE, EXEC and, when needed, MEM
// and WB. The FSM drives the per-cycle enables and selects, waits on the
// variable-latency instruction and data memories with a bounded timeout,
// and counts retired instructions.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   run             leave IDLE and begin fetching
//   halt            return to IDLE at the next retire boundary
//   imem_ready      instruction word valid this cycle
//   dmem_ready      data access complete this cycle
//   jump_type       decoder branch/jump class (nop/beq/jal/jr/j/bodd)
//   we_dmem         decoder: store
//   we_regfile      decoder: register writeback requested
//   en_rdata        decoder: load
//   alu_zero        rs1 == rs2, valid in EXEC
//   rs1_odd         bit 0 of rs1, valid in EXEC
//   imem_req        instruction fetch request
//   ir_we           latch the instruction register
//   pc_we, pc_sel   PC write enable and next-PC source
//   dmem_req        data memory request
//   dmem_we         data memory write qualifier
//   rf_we, rf_wsel  register file write enable and data source
//   busy            FSM is executing (not IDLE, not ERR)
//   err             sticky memory timeout flag
//   retired         retired-instruction count, wraps
//   state           current FSM state encoding
// ---------------------------------------------------------------------------
module mc_ctrl #(
    parameter int DWIDTH  = 32,
    parameter int TMO_W   = 4,
    parameter int TMO_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              halt,
    input  logic              imem_ready,
    input  logic              dmem_ready,
    input  logic [2:0]        jump_type,
    input  logic              we_dmem,
    input  logic              we_regfile,
    input  logic              en_rdata,
    input  logic              alu_zero,
    input  logic              rs1_odd,
    output logic              imem_req,
    output logic              ir_we,
    output logic              pc_we,
    output logic [1:0]        pc_sel,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic              rf_we,
    output logic [1:0]        rf_wsel,
    output logic              busy,
    output logic              err,
    output logic [DWIDTH-1:0] retired,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_FETCH  = 3'b001,
        S_DECODE = 3'b010,
        S_EXEC   = 3'b011,
        S_MEM    = 3'b100,
        S_WB     = 3'b101,
        S_ERR    = 3'b111
    } state_t;

    localparam logic [2:0] JT_NOP  = 3'b000;
    localparam logic [2:0] JT_BEQ  = 3'b001;
    localparam logic [2:0] JT_JAL  = 3'b010;
    localparam logic [2:0] JT_JR   = 3'b011;
    localparam logic [2:0] JT_J    = 3'b100;
    localparam logic [2:0] JT_BODD = 3'b101;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS1    = 2'b11;

    localparam logic [1:0] WSEL_ALU  = 2'b00;
    localparam logic [1:0] WSEL_MEM  = 2'b01;
    localparam logic [1:0] WSEL_LINK = 2'b10;

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TMO_MAX);

    state_t            cur_state;
    state_t            next_state;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              retire;

    // State register plus the bookkeeping that rides on it. The timeout
    // counter only ever advances while a memory wait keeps the FSM parked
    // in FETCH or MEM; any transition restarts it from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= S_IDLE;
            tmo_cnt   <= '0;
            err       <= 1'b0;
            retired   <= '0;
        end else begin
            cur_state <= next_state;
            if (next_state != cur_state) begin
                tmo_cnt <= '0;
            end else if (cur_state == S_FETCH || cur_state == S_MEM) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
            if (next_state == S_ERR) begin
                err <= 1'b1;
            end
            if (retire) begin
                retired <= retired + DWIDTH'(1);
            end
        end
    end

    // Next-state logic. A ready seen on the same cycle the wait count sits
    // at the limit still completes the access, because ready is tested
    // first. Every retire funnels through one point so halt is only ever
    // looked at on an instruction boundary.
    always_comb begin
        next_state = cur_state;
        retire     = 1'b0;
        case (cur_state)
            S_IDLE: begin
                if (run) next_state = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ready)                 next_state = S_DECODE;
                else if (tmo_cnt == TMO_LIMIT)  next_state = S_ERR;
            end
            S_DECODE: begin
                next_state = S_EXEC;
            end
            S_EXEC: begin
                case (jump_type)
                    JT_JAL: next_state = S_WB;
                    JT_NOP: begin
                        if (we_dmem || en_rdata) next_state = S_MEM;
                        else if (we_regfile)     next_state = S_WB;
                        else                     retire     = 1'b1;
                    end
                    default: retire = 1'b1;
                endcase
            end
            S_MEM: begin
                if (dmem_ready) begin
                    if (we_dmem) retire     = 1'b1;
                    else         next_state = S_WB;
                end else if (tmo_cnt == TMO_LIMIT) begin
                    next_state = S_ERR;
                end
            end
            S_WB: begin
                retire = 1'b1;
            end
            S_ERR: begin
                next_state = S_ERR;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
        if (retire) next_state = halt ? S_IDLE : S_FETCH;
    end

    // Output decode. Everything defaults low; branch and jump classes never
    // reach WB except jal, so the register file is only written for
    // ALU ops, loads and the jal link.
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = PC_PLUS4;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        rf_wsel  = WSEL_ALU;
        busy     = (cur_state != S_IDLE) && (cur_state != S_ERR);
        case (cur_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we  = 1'b1;
                    pc_we  = 1'b1;
                    pc_sel = PC_PLUS4;
                end
            end
            S_EXEC: begin
                case (jump_type)
                    JT_BEQ: begin
                        pc_we  = alu_zero;
                        pc_sel = alu_zero ? PC_BRANCH : PC_PLUS4;
                    end
                    JT_BODD: begin
                        pc_we  = rs1_odd;
                        pc_sel = rs1_odd ? PC_BRANCH : PC_PLUS4;
                    end
                    JT_J, JT_JAL: begin
                        pc_we  = 1'b1;
                        pc_sel = PC_JUMP;
                    end
                    JT_JR: begin
                        pc_we  = 1'b1;
                        pc_sel = PC_RS1;
                    end
                    default: begin
                        pc_we  = 1'b0;
                    end
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = we_dmem;
            end
            S_WB: begin
                rf_we = 1'b1;
                if (jump_type == JT_JAL) rf_wsel = WSEL_LINK;
                else if (en_rdata)       rf_wsel = WSEL_MEM;
                else                     rf_wsel = WSEL_ALU;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    assign state = cur_state;

endmodule
